// File: rtl/vend_pkg.sv
// vend_pkg: shared definitions for the nickel/dime vending controller.
//   state_e     one-hot controller states
//   COIN_*      coin values in nickels
//   PRICE*_DEF  default item prices in nickels
//   price_of()  price lookup for a latched item id (0 for the invalid id 0)
package vend_pkg;

  typedef enum logic [4:0] {
    ST_IDLE     = 5'b00001,
    ST_COLLECT  = 5'b00010,
    ST_DISPENSE = 5'b00100,
    ST_CHANGE   = 5'b01000,
    ST_REFUND   = 5'b10000
  } state_e;

  localparam int unsigned COIN_NICKEL = 1;
  localparam int unsigned COIN_DIME   = 2;

  localparam int unsigned PRICE1_DEF = 3;
  localparam int unsigned PRICE2_DEF = 4;
  localparam int unsigned PRICE3_DEF = 5;

  function automatic int unsigned price_of(input logic [1:0] item,
                                           input int unsigned p1,
                                           input int unsigned p2,
                                           input int unsigned p3);
    case (item)
      2'd1:    return p1;
      2'd2:    return p2;
      2'd3:    return p3;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/vend_coin_return.sv
// vend_coin_return: nickel return down-counter shared by change and refund.
//   clock, reset_n  system clock / async active-low reset
//   load_i          load load_val_i into the counter (takes priority)
//   load_val_i      number of nickels to return
//   count_o         nickels still owed, including the one being ejected now
//   nickel_o        registered pulse, high in every cycle count_o is non-zero
//   last_o          the counter reaches zero at the coming edge (or is already zero)
module vend_coin_return #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] count_o,
  output logic             nickel_o,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             nickel_q, nickel_d;

  always_comb begin
    cnt_d    = cnt_q;
    nickel_d = 1'b0;
    if (load_i) begin
      cnt_d    = load_val_i;
      nickel_d = (load_val_i != '0);
    end else if (cnt_q != '0) begin
      cnt_d    = cnt_q - CNT_W'(1);
      nickel_d = (cnt_q > CNT_W'(1));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      nickel_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      nickel_q <= nickel_d;
    end
  end

  assign count_o  = cnt_q;
  assign nickel_o = nickel_q;
  assign last_o   = (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/vend_controller.sv
// vend_controller: single-channel priced vending sequencer.
//   clock, reset_n         system clock / async active-low reset
//   item_sel, select_valid item request strobe (item 0 ignored)
//   nickel_in, dime_in     coin pulses
//   cancel                 customer abort pulse
//   dispense               one-cycle release pulse
//   nickel_out             one pulse per returned nickel
//   coin_reject            one-cycle pulse per diverted coin
//   item_id, credit, busy  latched item, credit in nickels, not-idle flag
//
// state       | meaning
// ------------+-----------------------------------------------
// ST_IDLE     | waiting for a valid selection, coins rejected
// ST_COLLECT  | item locked, accepting coins, timeout running
// ST_DISPENSE | one cycle, item released, price deducted
// ST_CHANGE   | returning overpayment one nickel per cycle
// ST_REFUND   | returning all credit after cancel/timeout
module vend_controller
  import vend_pkg::*;
#(
  parameter int unsigned PRICE1   = PRICE1_DEF,
  parameter int unsigned PRICE2   = PRICE2_DEF,
  parameter int unsigned PRICE3   = PRICE3_DEF,
  parameter int unsigned CREDIT_W = 4,
  parameter int unsigned TIMEOUT  = 1000,
  parameter int unsigned TMR_W    = 10
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [1:0]          item_sel,
  input  logic                select_valid,
  input  logic                nickel_in,
  input  logic                dime_in,
  input  logic                cancel,
  output logic                dispense,
  output logic                nickel_out,
  output logic                coin_reject,
  output logic [1:0]          item_id,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  state_e              state_q, state_d;
  logic [1:0]          item_q, item_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic                dispense_q, dispense_d;
  logic                reject_q, reject_d;
  logic                busy_q, busy_d;

  logic                ret_load;
  logic [CREDIT_W-1:0] ret_val;
  logic [CREDIT_W-1:0] ret_cnt;
  logic                ret_nickel;
  logic                ret_last;

  logic [CREDIT_W-1:0] price;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W-1:0] sum;
  logic                coin_any;

  vend_coin_return #(
    .CNT_W(CREDIT_W)
  ) u_coin_return (
    .clock      (clock),
    .reset_n    (reset_n),
    .load_i     (ret_load),
    .load_val_i (ret_val),
    .count_o    (ret_cnt),
    .nickel_o   (ret_nickel),
    .last_o     (ret_last)
  );

  // A simultaneous nickel and dime keeps the nickel; the dime is rejected.
  always_comb begin
    price    = CREDIT_W'(price_of(item_q, PRICE1, PRICE2, PRICE3));
    coin_any = nickel_in | dime_in;
    if (nickel_in)    coin_val = CREDIT_W'(COIN_NICKEL);
    else if (dime_in) coin_val = CREDIT_W'(COIN_DIME);
    else              coin_val = '0;
    sum = credit_q + coin_val;
  end

  // The idle timer is a down-counter reloaded with TIMEOUT on selection and
  // on every accepted coin; the TIMEOUT-th idle cycle triggers the refund.
  always_comb begin
    state_d  = state_q;
    item_d   = item_q;
    credit_d = credit_q;
    tmr_d    = tmr_q;
    reject_d = 1'b0;
    ret_load = 1'b0;
    ret_val  = credit_q;

    case (state_q)
      ST_IDLE: begin
        reject_d = coin_any;
        if (select_valid && (item_sel != 2'd0)) begin
          state_d  = ST_COLLECT;
          item_d   = item_sel;
          credit_d = '0;
          tmr_d    = TMR_W'(TIMEOUT);
        end
      end

      ST_COLLECT: begin
        if (cancel) begin
          reject_d = coin_any;
          state_d  = ST_REFUND;
          ret_load = 1'b1;
          credit_d = '0;
        end else if (coin_any) begin
          reject_d = nickel_in & dime_in;
          tmr_d    = TMR_W'(TIMEOUT);
          credit_d = sum;
          if (sum >= price) state_d = ST_DISPENSE;
        end else if (tmr_q <= TMR_W'(1)) begin
          state_d  = ST_REFUND;
          ret_load = 1'b1;
          credit_d = '0;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end

      ST_DISPENSE: begin
        reject_d = coin_any;
        credit_d = '0;
        if (credit_q > price) begin
          state_d  = ST_CHANGE;
          ret_load = 1'b1;
          ret_val  = credit_q - price;
        end else begin
          state_d = ST_IDLE;
          item_d  = 2'd0;
        end
      end

      ST_CHANGE, ST_REFUND: begin
        reject_d = coin_any;
        if (ret_last) begin
          state_d = ST_IDLE;
          item_d  = 2'd0;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        item_d   = 2'd0;
        credit_d = '0;
        tmr_d    = '0;
      end
    endcase

    dispense_d = (state_d == ST_DISPENSE);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      item_q     <= 2'd0;
      credit_q   <= '0;
      tmr_q      <= '0;
      dispense_q <= 1'b0;
      reject_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      item_q     <= item_d;
      credit_q   <= credit_d;
      tmr_q      <= tmr_d;
      dispense_q <= dispense_d;
      reject_q   <= reject_d;
      busy_q     <= busy_d;
    end
  end

  // While returning coins the owed amount lives in the return counter; both
  // sources are flops, so credit still only moves on a clock edge.
  assign credit      = ((state_q == ST_CHANGE) || (state_q == ST_REFUND)) ? ret_cnt : credit_q;
  assign dispense    = dispense_q;
  assign nickel_out  = ret_nickel;
  assign coin_reject = reject_q;
  assign item_id     = item_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_vend_controller.sv
module tb_vend_controller;

  localparam int TIMEOUT  = 1000;
  localparam int CREDIT_W = 4;

  localparam int P_IDLE    = 0;
  localparam int P_COLLECT = 1;
  localparam int P_DISP    = 2;
  localparam int P_PAYBACK = 3;

  logic                clock;
  logic                reset_n;
  logic [1:0]          item_sel;
  logic                select_valid;
  logic                nickel_in;
  logic                dime_in;
  logic                cancel;
  logic                dispense;
  logic                nickel_out;
  logic                coin_reject;
  logic [1:0]          item_id;
  logic [CREDIT_W-1:0] credit;
  logic                busy;

  vend_controller #(
    .TIMEOUT (TIMEOUT),
    .CREDIT_W(CREDIT_W)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .item_sel    (item_sel),
    .select_valid(select_valid),
    .nickel_in   (nickel_in),
    .dime_in     (dime_in),
    .cancel      (cancel),
    .dispense    (dispense),
    .nickel_out  (nickel_out),
    .coin_reject (coin_reject),
    .item_id     (item_id),
    .credit      (credit),
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int nick_seen = 0;
  int disp_seen = 0;
  int rej_seen = 0;

  // Reference model: transaction phase, credit in nickels, idle cycle count.
  int price_tab [4] = '{0, 3, 4, 5};
  int m_phase, m_item, m_credit, m_idle, m_reject;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase  = P_IDLE;
    m_item   = 0;
    m_credit = 0;
    m_idle   = 0;
    m_reject = 0;
  endtask

  task automatic model_step(input logic sv, input int id, input logic n,
                            input logic d, input logic c);
    int got;
    m_reject = 0;
    case (m_phase)
      P_IDLE: begin
        m_reject = int'(n | d);
        if (sv && id != 0) begin
          m_phase  = P_COLLECT;
          m_item   = id;
          m_credit = 0;
          m_idle   = 0;
        end
      end
      P_COLLECT: begin
        got = n ? 1 : (d ? 2 : 0);
        if (c) begin
          m_reject = int'(n | d);
          m_phase  = P_PAYBACK;
        end else if (got > 0) begin
          m_reject = int'(n & d);
          m_credit += got;
          m_idle   = 0;
          if (m_credit >= price_tab[m_item]) m_phase = P_DISP;
        end else begin
          m_idle++;
          if (m_idle >= TIMEOUT) m_phase = P_PAYBACK;
        end
      end
      P_DISP: begin
        m_reject = int'(n | d);
        m_credit -= price_tab[m_item];
        if (m_credit > 0) m_phase = P_PAYBACK;
        else begin
          m_phase = P_IDLE;
          m_item  = 0;
        end
      end
      default: begin
        m_reject = int'(n | d);
        if (m_credit <= 1) begin
          m_phase  = P_IDLE;
          m_item   = 0;
          m_credit = 0;
        end else begin
          m_credit--;
        end
      end
    endcase
  endtask

  task automatic compare_all();
    check("dispense",    int'(dispense),    int'(m_phase == P_DISP));
    check("nickel_out",  int'(nickel_out),  int'(m_phase == P_PAYBACK && m_credit > 0));
    check("coin_reject", int'(coin_reject), m_reject);
    check("item_id",     int'(item_id),     m_item);
    check("credit",      int'(credit),      m_credit);
    check("busy",        int'(busy),        int'(m_phase != P_IDLE));
  endtask

  task automatic step(input logic sv, input logic [1:0] id, input logic n,
                      input logic d, input logic c);
    select_valid = sv;
    item_sel     = id;
    nickel_in    = n;
    dime_in      = d;
    cancel       = c;
    @(posedge clock);
    model_step(sv, int'(id), n, d, c);
    #1;
    compare_all();
    if (nickel_out)  nick_seen++;
    if (dispense)    disp_seen++;
    if (coin_reject) rej_seen++;
    select_valid = 1'b0;
    item_sel     = 2'd0;
    nickel_in    = 1'b0;
    dime_in      = 1'b0;
    cancel       = 1'b0;
  endtask

  task automatic idle_steps(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clear_counts();
    nick_seen = 0;
    disp_seen = 0;
    rej_seen  = 0;
  endtask

  initial begin
    reset_n      = 1'b0;
    item_sel     = 2'd0;
    select_valid = 1'b0;
    nickel_in    = 1'b0;
    dime_in      = 1'b0;
    cancel       = 1'b0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    compare_all();
    #3 reset_n = 1'b1;

    // Item 1 paid with two dimes: dispense, one change nickel, back to idle.
    clear_counts();
    step(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    check("s1_item_latched", int'(item_id), 1);
    step(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    check("s1_dispense_after_2nd_dime", int'(dispense), 1);
    check("s1_credit_4", int'(credit), 4);
    idle_steps(3);
    check("s1_nickels", nick_seen, 1);
    check("s1_busy_end", int'(busy), 0);

    // Item 3 paid exactly with five nickels: no change.
    clear_counts();
    step(1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    check("s2_dispense", int'(dispense), 1);
    idle_steps(2);
    check("s2_nickels", nick_seen, 0);
    check("s2_credit", int'(credit), 0);

    // Item 2, dime + nickel then cancel: three refund nickels.
    clear_counts();
    step(1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    step(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    idle_steps(5);
    check("s3_refund_nickels", nick_seen, 3);
    check("s3_item_cleared", int'(item_id), 0);
    check("s3_no_dispense", disp_seen, 0);

    // Simultaneous coins, then cancel together with a dime.
    clear_counts();
    step(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
    check("s4_credit_1", int'(credit), 1);
    check("s4_dime_rejected", int'(coin_reject), 1);
    step(1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
    check("s4_cancel_dime_rejected", int'(coin_reject), 1);
    idle_steps(3);
    check("s4_refund_nickels", nick_seen, 1);

    // Timeout refund, then a coin in idle is only rejected.
    clear_counts();
    step(1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    step(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    idle_steps(TIMEOUT - 1);
    check("s5_no_early_refund", nick_seen, 0);
    check("s5_still_busy", int'(busy), 1);
    idle_steps(4);
    check("s5_timeout_nickels", nick_seen, 2);
    step(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    check("s5_idle_reject", int'(coin_reject), 1);
    check("s5_idle_busy", int'(busy), 0);

    // Asynchronous reset in the middle of collecting (credit 3).
    clear_counts();
    step(1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    step(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    check("s6_credit_3", int'(credit), 3);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      check("s6_no_refund_in_reset", int'(nickel_out), 0);
    end
    #2 reset_n = 1'b1;
    step(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    check("s6_resume_dispense", int'(dispense), 1);
    idle_steps(2);

    // Random traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 5) == 0),
           1'($urandom_range(0, 39) == 0));
    end
    idle_steps(10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
